// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipe_ctrl_if : stage handshake bundle between controller and stages    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface pipe_ctrl_if;
  logic IF_over;
  logic ID_over;
  logic EXE_over;
  logic MEM_over;
  logic WB_over;
  logic exc_valid;
  logic IF_valid;
  logic ID_valid;
  logic EXE_valid;
  logic MEM_valid;
  logic WB_valid;
  logic next_fetch;
  logic cancel;

  modport master (
    input  IF_over, ID_over, EXE_over, MEM_over, WB_over, exc_valid,
    output IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid,
    output next_fetch, cancel
  );

  modport slave (
    output IF_over, ID_over, EXE_over, MEM_over, WB_over, exc_valid,
    input  IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid,
    input  next_fetch, cancel
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipe_ctrl : five-stage valid/allow-in sequencer with halt FSM, counters|
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  pipe_ctrl_if.master      pif,
  input  logic             halt_req,
  input  logic             resume,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_id_valid;
  logic             r_exe_valid;
  logic             r_mem_valid;
  logic             r_wb_valid;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_inst_cnt;

  logic w_if_valid;
  logic w_cancel;
  logic w_wb_allow_in;
  logic w_mem_allow_in;
  logic w_exe_allow_in;
  logic w_id_allow_in;
  logic w_any_valid;
  logic w_fetch_open;
  logic w_retire;

  assign w_if_valid = (r_state == ST_RUN);
  assign w_cancel   = pif.exc_valid;

  // Allow-in ripples back from WB: a stage can take new work when empty
  // or when its occupant is leaving this cycle.
  assign w_wb_allow_in  = !r_wb_valid  | pif.WB_over;
  assign w_mem_allow_in = !r_mem_valid | (pif.MEM_over & w_wb_allow_in);
  assign w_exe_allow_in = !r_exe_valid | (pif.EXE_over & w_mem_allow_in);
  assign w_id_allow_in  = !r_id_valid  | (pif.ID_over  & w_exe_allow_in);

  assign w_any_valid  = r_id_valid | r_exe_valid | r_mem_valid | r_wb_valid;
  assign w_fetch_open = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_retire     = r_wb_valid & pif.WB_over;

  assign pif.IF_valid   = w_if_valid;
  assign pif.ID_valid   = r_id_valid;
  assign pif.EXE_valid  = r_exe_valid;
  assign pif.MEM_valid  = r_mem_valid;
  assign pif.WB_valid   = r_wb_valid;
  assign pif.cancel     = w_cancel;
  assign pif.next_fetch = w_fetch_open &
                          ((w_if_valid & pif.IF_over & w_id_allow_in) | w_cancel);

  assign halted    = (r_state == ST_HALTED);
  assign cycle_cnt = r_cycle_cnt;
  assign inst_cnt  = r_inst_cnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT:   w_state_nxt = ST_RUN;
      // An exception outranks a halt request; halt is seen again next cycle.
      ST_RUN:    if (halt_req && !w_cancel) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!w_any_valid)  w_state_nxt = ST_HALTED;
        else if (!halt_req) w_state_nxt = ST_RUN;
      end
      ST_HALTED: if (resume && !halt_req) w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_BOOT;
      r_id_valid  <= 1'b0;
      r_exe_valid <= 1'b0;
      r_mem_valid <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_cancel)           r_id_valid <= 1'b0;
      else if (w_id_allow_in) r_id_valid <= w_if_valid & pif.IF_over;

      if (w_cancel)            r_exe_valid <= 1'b0;
      else if (w_exe_allow_in) r_exe_valid <= r_id_valid & pif.ID_over;

      if (w_cancel)            r_mem_valid <= 1'b0;
      else if (w_mem_allow_in) r_mem_valid <= r_exe_valid & pif.EXE_over;

      // WB itself is never flushed: the excepting instruction retires.
      if (w_wb_allow_in) r_wb_valid <= r_mem_valid & pif.MEM_over & !w_cancel;

      if (w_fetch_open) r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
      if (w_retire)     r_inst_cnt  <= r_inst_cnt + CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pipe_ctrl : cycle-by-cycle directed vectors for pipe_ctrl (CNT_W=4) |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_pipe_ctrl;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [4:0] over;   // {IF,ID,EXE,MEM,WB}
    logic       exc;
    logic       halt;
    logic       res;
    logic [4:0] v;      // {IF,ID,EXE,MEM,WB} valid
    logic       nf;
    logic       cn;
    logic       hl;
    logic [3:0] ic;
    logic [3:0] cc;
  } vec_t;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             halt_req = 1'b0;
  logic             resume = 1'b0;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] inst_cnt;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  pipe_ctrl_if pif();

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pif       (pif),
    .halt_req  (halt_req),
    .resume    (resume),
    .halted    (halted),
    .cycle_cnt (cycle_cnt),
    .inst_cnt  (inst_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obs();
    return {pif.IF_valid, pif.ID_valid, pif.EXE_valid, pif.MEM_valid, pif.WB_valid,
            pif.next_fetch, pif.cancel, halted, inst_cnt, cycle_cnt};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got v=%b nf=%b cn=%b hl=%b ic=%0d cc=%0d want v=%b nf=%b cn=%b hl=%b ic=%0d cc=%0d",
               name, act[15:11], act[10], act[9], act[8], act[7:4], act[3:0],
               exp[15:11], exp[10], exp[9], exp[8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic add(input logic [4:0] over, input logic exc, input logic halt,
                     input logic res, input logic [4:0] v, input logic nf,
                     input logic cn, input logic hl, input logic [3:0] ic,
                     input logic [3:0] cc);
    vec_t t;
    t = {over, exc, halt, res, v, nf, cn, hl, ic, cc};
    tbl.push_back(t);
  endtask

  task automatic drive(input logic [4:0] over, input logic exc, input logic halt,
                       input logic res);
    {pif.IF_over, pif.ID_over, pif.EXE_over, pif.MEM_over, pif.WB_over} = over;
    pif.exc_valid = exc;
    halt_req      = halt;
    resume        = res;
  endtask

  initial begin
    logic [4:0] all1;
    logic [4:0] exe0;
    all1 = 5'b11111;
    exe0 = 5'b11011;

    // Boot, fill, steady flow (cycle_cnt wraps at row 17)
    add(all1, 0, 0, 0, 5'b00000, 0, 0, 0, 4'd0, 4'd0);
    add(all1, 0, 0, 0, 5'b10000, 1, 0, 0, 4'd0, 4'd0);
    add(all1, 0, 0, 0, 5'b11000, 1, 0, 0, 4'd0, 4'd1);
    add(all1, 0, 0, 0, 5'b11100, 1, 0, 0, 4'd0, 4'd2);
    add(all1, 0, 0, 0, 5'b11110, 1, 0, 0, 4'd0, 4'd3);
    add(all1, 0, 0, 0, 5'b11111, 1, 0, 0, 4'd0, 4'd4);
    for (int n = 6; n <= 17; n++)
      add(all1, 0, 0, 0, 5'b11111, 1, 0, 0, 4'(n - 5), 4'(n - 1));
    // EXE stall for 3 cycles
    add(exe0, 0, 0, 0, 5'b11111, 0, 0, 0, 4'd13, 4'd1);
    add(exe0, 0, 0, 0, 5'b11101, 0, 0, 0, 4'd14, 4'd2);
    add(exe0, 0, 0, 0, 5'b11100, 0, 0, 0, 4'd15, 4'd3);
    add(all1, 0, 0, 0, 5'b11100, 1, 0, 0, 4'd15, 4'd4);
    add(all1, 0, 0, 0, 5'b11110, 1, 0, 0, 4'd15, 4'd5);
    add(all1, 0, 0, 0, 5'b11111, 1, 0, 0, 4'd15, 4'd6);
    // Exception with full pipeline
    add(all1, 1, 0, 0, 5'b11111, 1, 1, 0, 4'd0, 4'd7);
    add(all1, 0, 0, 0, 5'b10000, 1, 0, 0, 4'd1, 4'd8);
    add(all1, 0, 0, 0, 5'b11000, 1, 0, 0, 4'd1, 4'd9);
    add(all1, 0, 0, 0, 5'b11100, 1, 0, 0, 4'd1, 4'd10);
    add(all1, 0, 0, 0, 5'b11110, 1, 0, 0, 4'd1, 4'd11);
    // Halt, drain, resume
    add(all1, 0, 1, 0, 5'b11111, 1, 0, 0, 4'd1, 4'd12);
    add(all1, 0, 1, 0, 5'b01111, 0, 0, 0, 4'd2, 4'd13);
    add(all1, 0, 1, 0, 5'b00111, 0, 0, 0, 4'd3, 4'd14);
    add(all1, 0, 1, 0, 5'b00011, 0, 0, 0, 4'd4, 4'd15);
    add(all1, 0, 1, 0, 5'b00001, 0, 0, 0, 4'd5, 4'd0);
    add(all1, 0, 1, 0, 5'b00000, 0, 0, 0, 4'd6, 4'd1);
    add(all1, 0, 1, 0, 5'b00000, 0, 0, 1, 4'd6, 4'd2);
    add(all1, 0, 1, 1, 5'b00000, 0, 0, 1, 4'd6, 4'd2);
    add(all1, 0, 0, 1, 5'b00000, 0, 0, 1, 4'd6, 4'd2);
    add(all1, 0, 0, 0, 5'b10000, 1, 0, 0, 4'd6, 4'd2);
    add(all1, 0, 0, 0, 5'b11000, 1, 0, 0, 4'd6, 4'd3);
    add(all1, 0, 0, 0, 5'b11100, 1, 0, 0, 4'd6, 4'd4);
    add(all1, 0, 0, 0, 5'b11110, 1, 0, 0, 4'd6, 4'd5);
    // Halt coinciding with exception, then drain aborted by halt drop
    add(all1, 1, 1, 0, 5'b11111, 1, 1, 0, 4'd6, 4'd6);
    add(all1, 0, 1, 0, 5'b10000, 1, 0, 0, 4'd7, 4'd7);
    add(all1, 0, 0, 0, 5'b01000, 0, 0, 0, 4'd7, 4'd8);
    add(all1, 0, 0, 0, 5'b10100, 1, 0, 0, 4'd7, 4'd9);
    add(all1, 0, 0, 0, 5'b11010, 1, 0, 0, 4'd7, 4'd10);
    add(all1, 0, 0, 0, 5'b11101, 1, 0, 0, 4'd7, 4'd11);
    // Exception during drain, then cancel while halted
    add(all1, 0, 1, 0, 5'b11110, 1, 0, 0, 4'd8, 4'd12);
    add(all1, 1, 1, 0, 5'b01111, 1, 1, 0, 4'd8, 4'd13);
    add(all1, 0, 1, 0, 5'b00000, 0, 0, 0, 4'd9, 4'd14);
    add(all1, 1, 1, 0, 5'b00000, 0, 1, 1, 4'd9, 4'd15);
    add(all1, 0, 0, 0, 5'b00000, 0, 0, 1, 4'd9, 4'd15);

    drive(5'b00000, 0, 0, 0);
    #2 check("reset_state", obs(), 16'h0000);
    @(posedge clk);
    @(negedge clk) check("reset_hold", obs(), 16'h0000);
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].over, tbl[i].exc, tbl[i].halt, tbl[i].res);
      if (i == 0) resetn = 1'b1;
      @(negedge clk);
      check($sformatf("row%0d", i), obs(),
            {tbl[i].v, tbl[i].nf, tbl[i].cn, tbl[i].hl, tbl[i].ic, tbl[i].cc});
      @(posedge clk);
      #1;
    end

    // Resume out of HALTED, refill, then asynchronous reset mid-cycle
    drive(5'b11111, 0, 0, 1);
    @(negedge clk) check("resume_cycle", obs(), {5'b00000, 1'b0, 1'b0, 1'b1, 4'd9, 4'd15});
    @(posedge clk);
    #1 resume = 1'b0;
    @(negedge clk) check("restart_fetch", obs(), {5'b10000, 1'b1, 1'b0, 1'b0, 4'd9, 4'd15});
    @(posedge clk);
    @(negedge clk) check("refill_1", obs(), {5'b11000, 1'b1, 1'b0, 1'b0, 4'd9, 4'd0});
    @(posedge clk);
    @(negedge clk) check("refill_2", obs(), {5'b11100, 1'b1, 1'b0, 1'b0, 4'd9, 4'd1});
    #2 resetn = 1'b0;
    #1 check("async_reset", obs(), 16'h0000);
    @(posedge clk);
    @(negedge clk) check("async_reset_hold", obs(), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
